// File: rtl/ssd1306_pkg.sv
// rtl/ssd1306_pkg.sv - shared opcodes, decoder states and addressing modes for the SSD1306 front end
package ssd1306_pkg;

    localparam logic [7:0] OP_SET_MODE  = 8'h20;
    localparam logic [7:0] OP_COL_ADDR  = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
    localparam logic [7:0] OP_CONTRAST  = 8'h81;
    localparam logic [7:0] OP_ALL_OFF   = 8'hA4;
    localparam logic [7:0] OP_ALL_ON    = 8'hA5;
    localparam logic [7:0] OP_INV_OFF   = 8'hA6;
    localparam logic [7:0] OP_INV_ON    = 8'hA7;
    localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
    localparam logic [7:0] OP_DISP_ON   = 8'hAF;
    localparam logic [7:0] OP_PAGE_BASE = 8'hB0;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_MODE,
        ST_COL0,
        ST_COL1,
        ST_PG0,
        ST_PG1,
        ST_CONTRAST,
        ST_SKIP
    } cmdState_t;

    typedef enum logic [1:0] {
        MODE_HORIZ = 2'd0,
        MODE_VERT  = 2'd1,
        MODE_PAGE  = 2'd2
    } addrMode_t;

    // One-argument commands whose argument only affects panel analog/timing setup.
    function automatic logic isSkipOp(input logic [7:0] op);
        case (op)
            8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ssd1306_addr_gen.sv
// rtl/ssd1306_addr_gen.sv - column/page pointers, address windows and per-mode pointer advance
module ssd1306_addr_gen
    import ssd1306_pkg::*;
#(
    parameter int COLS = 128
) (
    input  logic       oled_clk,
    input  logic       reset,
    input  logic       dataStrobe,
    input  logic [1:0] addrMode,
    input  logic       ldColLo,
    input  logic       ldColHi,
    input  logic       ldPage,
    input  logic       ldColWin,
    input  logic       ldColEnd,
    input  logic       ldPageWin,
    input  logic       ldPageEnd,
    input  logic [7:0] loadVal,
    output logic [9:0] fb_waddr
);

    logic [6:0] col, colStart, colEnd, colNext;
    logic [2:0] page, pageStart, pageEnd, pageNext;

    // Equality-only window matching: an end below start runs to the natural wrap first.
    always_comb begin
        colNext  = col;
        pageNext = page;
        case (addrMode)
            MODE_HORIZ: begin
                if (col == colEnd) begin
                    colNext  = colStart;
                    pageNext = (page == pageEnd) ? pageStart : page + 3'd1;
                end else begin
                    colNext = col + 7'd1;
                end
            end
            MODE_VERT: begin
                if (page == pageEnd) begin
                    pageNext = pageStart;
                    colNext  = (col == colEnd) ? colStart : col + 7'd1;
                end else begin
                    pageNext = page + 3'd1;
                end
            end
            default: colNext = col + 7'd1;
        endcase
    end

    always_ff @(posedge oled_clk or posedge reset) begin
        if (reset) begin
            col       <= 7'd0;
            page      <= 3'd0;
            colStart  <= 7'd0;
            colEnd    <= 7'd127;
            pageStart <= 3'd0;
            pageEnd   <= 3'd7;
        end else begin
            if (ldColLo) col[3:0] <= loadVal[3:0];
            if (ldColHi) col[6:4] <= loadVal[2:0];
            if (ldPage) page <= loadVal[2:0];
            if (ldColWin) begin
                colStart <= loadVal[6:0];
                col      <= loadVal[6:0];
            end
            if (ldColEnd) colEnd <= loadVal[6:0];
            if (ldPageWin) begin
                pageStart <= loadVal[2:0];
                page      <= loadVal[2:0];
            end
            if (ldPageEnd) pageEnd <= loadVal[2:0];
            if (dataStrobe) begin
                col  <= colNext;
                page <= pageNext;
            end
        end
    end

    assign fb_waddr = 10'(page) * 10'(COLS) + 10'(col);

endmodule

// File: rtl/ssd1306_cmd_decoder.sv
// rtl/ssd1306_cmd_decoder.sv - SSD1306 SPI deserialiser, command FSM and framebuffer write port
module ssd1306_cmd_decoder
    import ssd1306_pkg::*;
#(
    parameter int         COLS         = 128,
    parameter int         PAGES        = 8,
    parameter logic [7:0] CONTRAST_RST = 8'h7F
) (
    input  logic       oled_clk,
    input  logic       reset,
    input  logic       oled_cs_n,
    input  logic       oled_dc,
    input  logic       oled_data,
    output logic       fb_we,
    output logic [9:0] fb_waddr,
    output logic [7:0] fb_wdata,
    output logic       invert,
    output logic       display_on,
    output logic       all_on,
    output logic [7:0] contrast,
    output logic [5:0] start_line,
    output logic [1:0] addr_mode
);

    logic [2:0] bitCnt;
    logic [6:0] shiftReg;
    logic       byteDone, dataStrobe, cmdStrobe;
    logic [7:0] byteVal;

    cmdState_t  state, nextState;
    addrMode_t  addrModeReg, addrModeNxt;
    logic       invertNxt, displayOnNxt, allOnNxt;
    logic [7:0] contrastNxt;
    logic [5:0] startLineNxt;
    logic       ldColLo, ldColHi, ldPage, ldColWin, ldColEnd, ldPageWin, ldPageEnd;

    assign byteDone   = !oled_cs_n && (bitCnt == 3'd7);
    assign byteVal    = {shiftReg, oled_data};
    assign dataStrobe = byteDone && oled_dc;
    assign cmdStrobe  = byteDone && !oled_dc;

    always_ff @(posedge oled_clk or posedge reset) begin
        if (reset) begin
            bitCnt   <= 3'd0;
            shiftReg <= 7'd0;
        end else if (oled_cs_n) begin
            bitCnt <= 3'd0;
        end else begin
            bitCnt   <= bitCnt + 3'd1;
            shiftReg <= {shiftReg[5:0], oled_data};
        end
    end

    always_ff @(posedge oled_clk or posedge reset) begin
        if (reset) begin
            state       <= ST_CMD;
            addrModeReg <= MODE_PAGE;
            invert      <= 1'b0;
            display_on  <= 1'b0;
            all_on      <= 1'b0;
            contrast    <= CONTRAST_RST;
            start_line  <= 6'd0;
        end else begin
            state       <= nextState;
            addrModeReg <= addrModeNxt;
            invert      <= invertNxt;
            display_on  <= displayOnNxt;
            all_on      <= allOnNxt;
            contrast    <= contrastNxt;
            start_line  <= startLineNxt;
        end
    end

    always_comb begin
        nextState    = state;
        addrModeNxt  = addrModeReg;
        invertNxt    = invert;
        displayOnNxt = display_on;
        allOnNxt     = all_on;
        contrastNxt  = contrast;
        startLineNxt = start_line;
        ldColLo      = 1'b0;
        ldColHi      = 1'b0;
        ldPage       = 1'b0;
        ldColWin     = 1'b0;
        ldColEnd     = 1'b0;
        ldPageWin    = 1'b0;
        ldPageEnd    = 1'b0;
        if (dataStrobe) begin
            // A data byte where an argument was expected abandons the command.
            nextState = ST_CMD;
        end else if (cmdStrobe) begin
            case (state)
                ST_CMD: begin
                    if (byteVal[7:4] == 4'h0) ldColLo = 1'b1;
                    else if (byteVal[7:4] == 4'h1) ldColHi = 1'b1;
                    else if (byteVal[7:6] == 2'b01) startLineNxt = byteVal[5:0];
                    else if (byteVal[7:3] == OP_PAGE_BASE[7:3]) ldPage = 1'b1;
                    else begin
                        case (byteVal)
                            OP_SET_MODE:  nextState = ST_MODE;
                            OP_COL_ADDR:  nextState = ST_COL0;
                            OP_PAGE_ADDR: nextState = ST_PG0;
                            OP_CONTRAST:  nextState = ST_CONTRAST;
                            OP_ALL_OFF:   allOnNxt = 1'b0;
                            OP_ALL_ON:    allOnNxt = 1'b1;
                            OP_INV_OFF:   invertNxt = 1'b0;
                            OP_INV_ON:    invertNxt = 1'b1;
                            OP_DISP_OFF:  displayOnNxt = 1'b0;
                            OP_DISP_ON:   displayOnNxt = 1'b1;
                            default:      if (isSkipOp(byteVal)) nextState = ST_SKIP;
                        endcase
                    end
                end
                ST_MODE: begin
                    addrModeNxt = (byteVal[1:0] == 2'b11) ? MODE_PAGE : addrMode_t'(byteVal[1:0]);
                    nextState   = ST_CMD;
                end
                ST_COL0: begin
                    ldColWin  = 1'b1;
                    nextState = ST_COL1;
                end
                ST_COL1: begin
                    ldColEnd  = 1'b1;
                    nextState = ST_CMD;
                end
                ST_PG0: begin
                    ldPageWin = 1'b1;
                    nextState = ST_PG1;
                end
                ST_PG1: begin
                    ldPageEnd = 1'b1;
                    nextState = ST_CMD;
                end
                ST_CONTRAST: begin
                    contrastNxt = byteVal;
                    nextState   = ST_CMD;
                end
                default: nextState = ST_CMD;
            endcase
        end
    end

    ssd1306_addr_gen #(
        .COLS(COLS)
    ) addrGen (
        .oled_clk  (oled_clk),
        .reset     (reset),
        .dataStrobe(dataStrobe),
        .addrMode  (addrModeReg),
        .ldColLo   (ldColLo),
        .ldColHi   (ldColHi),
        .ldPage    (ldPage),
        .ldColWin  (ldColWin),
        .ldColEnd  (ldColEnd),
        .ldPageWin (ldPageWin),
        .ldPageEnd (ldPageEnd),
        .loadVal   (byteVal),
        .fb_waddr  (fb_waddr)
    );

    assign fb_we     = dataStrobe;
    assign fb_wdata  = byteVal;
    assign addr_mode = addrModeReg;

endmodule

// File: tb/tb_ssd1306_cmd_decoder.sv
// tb/tb_ssd1306_cmd_decoder.sv - randomized and directed bench for ssd1306_cmd_decoder against a byte-level model
module tb_ssd1306_cmd_decoder;

    logic       oled_clk = 1'b0;
    logic       reset = 1'b1;
    logic       oled_cs_n = 1'b1;
    logic       oled_dc = 1'b0;
    logic       oled_data = 1'b0;
    logic       fb_we;
    logic [9:0] fb_waddr;
    logic [7:0] fb_wdata;
    logic       invert, display_on, all_on;
    logic [7:0] contrast;
    logic [5:0] start_line;
    logic [1:0] addr_mode;

    always #5 oled_clk = ~oled_clk;

    ssd1306_cmd_decoder #(
        .COLS(128),
        .PAGES(8),
        .CONTRAST_RST(8'h7F)
    ) dut (
        .oled_clk  (oled_clk),
        .reset     (reset),
        .oled_cs_n (oled_cs_n),
        .oled_dc   (oled_dc),
        .oled_data (oled_data),
        .fb_we     (fb_we),
        .fb_waddr  (fb_waddr),
        .fb_wdata  (fb_wdata),
        .invert    (invert),
        .display_on(display_on),
        .all_on    (all_on),
        .contrast  (contrast),
        .start_line(start_line),
        .addr_mode (addr_mode)
    );

    int checks = 0;
    int errors = 0;

    // Byte-level model state: pointers, windows, display state, pending multi-byte command.
    logic [6:0] mCol, mColStart, mColEnd, mShift;
    logic [2:0] mPage, mPageStart, mPageEnd;
    logic [1:0] mMode;
    logic       mInv, mDisp, mAll;
    logic [7:0] mContrast, mPendOp;
    logic [5:0] mStart;
    int         mBits, mArgIdx;

    bit         recording = 0;
    int         gotAddr[$];
    logic [7:0] gotData[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mCol = 0; mPage = 0; mColStart = 0; mColEnd = 7'd127; mPageStart = 0; mPageEnd = 3'd7;
        mMode = 2; mInv = 0; mDisp = 0; mAll = 0; mContrast = 8'h7F; mStart = 0;
        mBits = 0; mShift = 0; mPendOp = 0; mArgIdx = 0;
    endtask

    task automatic modelAdvance();
        if (mMode == 0) begin
            if (mCol == mColEnd) begin
                mCol  = mColStart;
                mPage = (mPage == mPageEnd) ? mPageStart : mPage + 3'd1;
            end else mCol = mCol + 7'd1;
        end else if (mMode == 1) begin
            if (mPage == mPageEnd) begin
                mPage = mPageStart;
                mCol  = (mCol == mColEnd) ? mColStart : mCol + 7'd1;
            end else mPage = mPage + 3'd1;
        end else mCol = mCol + 7'd1;
    endtask

    task automatic modelOp(input logic [7:0] b);
        if (b < 8'h10) mCol[3:0] = b[3:0];
        else if (b < 8'h20) mCol[6:4] = b[2:0];
        else if (b >= 8'h40 && b < 8'h80) mStart = b[5:0];
        else if (b >= 8'hB0 && b <= 8'hB7) mPage = b[2:0];
        else case (b)
            8'h20, 8'h21, 8'h22, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
                mPendOp = b;
                mArgIdx = 0;
            end
            8'hA4: mAll = 0;
            8'hA5: mAll = 1;
            8'hA6: mInv = 0;
            8'hA7: mInv = 1;
            8'hAE: mDisp = 0;
            8'hAF: mDisp = 1;
            default: ;
        endcase
    endtask

    task automatic modelArg(input logic [7:0] b);
        case (mPendOp)
            8'h20: begin mMode = (b[1:0] == 2'd3) ? 2'd2 : b[1:0]; mPendOp = 0; end
            8'h21: if (mArgIdx == 0) begin mColStart = b[6:0]; mCol = b[6:0]; mArgIdx = 1; end
                   else begin mColEnd = b[6:0]; mPendOp = 0; end
            8'h22: if (mArgIdx == 0) begin mPageStart = b[2:0]; mPage = b[2:0]; mArgIdx = 1; end
                   else begin mPageEnd = b[2:0]; mPendOp = 0; end
            8'h81: begin mContrast = b; mPendOp = 0; end
            default: mPendOp = 0;
        endcase
    endtask

    task automatic modelBit(input logic cs, input logic dc, input logic d);
        logic [7:0] b;
        if (cs) begin
            mBits = 0;
            return;
        end
        if (mBits < 7) begin
            mShift = {mShift[5:0], d};
            mBits++;
            return;
        end
        b = {mShift, d};
        mBits = 0;
        if (dc) begin
            mPendOp = 0;
            modelAdvance();
        end else if (mPendOp != 0) modelArg(b);
        else modelOp(b);
    endtask

    always @(posedge oled_clk) begin
        if (reset) modelReset();
        else modelBit(oled_cs_n, oled_dc, oled_data);
    end

    // Compare process: inputs change on the falling edge, outputs are checked 2 ns later.
    always @(negedge oled_clk) begin
        logic expWe;
        #2;
        if (!reset) begin
            expWe = !oled_cs_n && (mBits == 7) && oled_dc;
            check("fb_we", fb_we, expWe);
            if (expWe) begin
                check("fb_waddr", fb_waddr, int'(mPage) * 128 + int'(mCol));
                check("fb_wdata", fb_wdata, {mShift, oled_data});
                if (recording) begin
                    gotAddr.push_back(int'(fb_waddr));
                    gotData.push_back(fb_wdata);
                end
            end
            check("invert", invert, mInv);
            check("display_on", display_on, mDisp);
            check("all_on", all_on, mAll);
            check("contrast", contrast, mContrast);
            check("start_line", start_line, mStart);
            check("addr_mode", addr_mode, mMode);
        end
    end

    task automatic sendBits(input logic dc, input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge oled_clk);
            oled_cs_n = 0;
            oled_dc   = dc;
            oled_data = b[i];
        end
    endtask

    task automatic sendByte(input logic dc, input logic [7:0] b);
        sendBits(dc, b, 8);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge oled_clk);
            oled_cs_n = 1;
        end
    endtask

    task automatic doReset();
        @(negedge oled_clk);
        reset = 1;
        oled_cs_n = 1;
        @(negedge oled_clk);
        @(negedge oled_clk);
        reset = 0;
    endtask

    task automatic startRec();
        gotAddr.delete();
        gotData.delete();
        recording = 1;
    endtask

    task automatic cmdSeq(input logic [7:0] a, b, c, d, e, f, g, h);
        sendByte(0, a); sendByte(0, b); sendByte(0, c); sendByte(0, d);
        sendByte(0, e); sendByte(0, f); sendByte(0, g); sendByte(0, h);
    endtask

    initial begin
        int exp3[5];
        int exp4[5];
        int firstBad;
        logic [7:0] ops[17];
        exp3 = '{272, 273, 400, 401, 272};
        exp4 = '{773, 901, 774, 902, 773};
        ops = '{8'h20, 8'h21, 8'h22, 8'h81, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hAE, 8'hAF,
                8'h8D, 8'hA8, 8'hD3, 8'hB0, 8'h00, 8'h10, 8'h40};

        doReset();
        #3;
        check("rst contrast", contrast, 8'h7F);
        check("rst addr_mode", addr_mode, 2'd2);
        check("rst display_on", display_on, 1'b0);
        check("rst invert", invert, 1'b0);
        check("rst all_on", all_on, 1'b0);
        check("rst start_line", start_line, 6'd0);

        sendByte(0, 8'hAF);
        sendByte(0, 8'hA7);
        startRec();
        sendByte(1, 8'h5A);
        idle(2);
        check("t1 display_on", display_on, 1'b1);
        check("t1 invert", invert, 1'b1);
        check("t1 count", gotAddr.size(), 1);
        check("t1 addr", gotAddr[0], 0);
        check("t1 data", gotData[0], 8'h5A);
        check("t1 model col", mCol, 7'd1);

        cmdSeq(8'h20, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07);
        startRec();
        for (int i = 0; i < 1025; i++) sendByte(1, 8'($urandom));
        idle(2);
        check("t2 count", gotAddr.size(), 1025);
        firstBad = -1;
        for (int i = 0; i < 1024; i++)
            if (firstBad < 0 && gotAddr[i] != i) firstBad = i;
        check("t2 first out-of-order index", firstBad, -1);
        check("t2 wrap addr", gotAddr[1024], 0);

        cmdSeq(8'h20, 8'h00, 8'h21, 8'h10, 8'h11, 8'h22, 8'h02, 8'h03);
        startRec();
        for (int i = 0; i < 5; i++) sendByte(1, 8'($urandom));
        idle(2);
        check("t3 count", gotAddr.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("t3 addr%0d", i), gotAddr[i], exp3[i]);

        cmdSeq(8'h20, 8'h01, 8'h21, 8'h05, 8'h06, 8'h22, 8'h06, 8'h07);
        startRec();
        for (int i = 0; i < 5; i++) sendByte(1, 8'($urandom));
        idle(2);
        check("t4 count", gotAddr.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("t4 addr%0d", i), gotAddr[i], exp4[i]);

        doReset();
        startRec();
        sendByte(0, 8'h81);
        sendByte(1, 8'h33);
        sendByte(0, 8'hB3);
        sendByte(1, 8'h99);
        idle(2);
        check("t5 contrast", contrast, 8'h7F);
        check("t5 count", gotAddr.size(), 2);
        check("t5 addr0", gotAddr[0], 0);
        check("t5 data0", gotData[0], 8'h33);
        check("t5 addr1", gotAddr[1], 385);

        doReset();
        sendBits(1, 8'hFF, 5);
        doReset();
        startRec();
        sendByte(1, 8'hC3);
        idle(1);
        sendBits(1, 8'hA5, 5);
        idle(1);
        sendByte(1, 8'h3C);
        idle(2);
        check("t6 count", gotAddr.size(), 2);
        check("t6 addr0", gotAddr[0], 0);
        check("t6 data0", gotData[0], 8'hC3);
        check("t6 addr1", gotAddr[1], 1);
        check("t6 data1", gotData[1], 8'h3C);
        recording = 0;

        doReset();
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [7:0] op;
            r = $urandom_range(0, 9);
            if (r < 4) sendByte(1, 8'($urandom));
            else if (r < 8) begin
                op = ops[$urandom_range(0, 16)];
                if (op == 8'hB0) op = op | 8'($urandom_range(0, 7));
                else if (op == 8'h00 || op == 8'h10) op = op | 8'($urandom_range(0, 15));
                else if (op == 8'h40) op = op | 8'($urandom_range(0, 63));
                sendByte(0, op);
                for (int k = $urandom_range(0, 2); k > 0; k--) sendByte(0, 8'($urandom));
            end else if (r == 8) sendByte(0, 8'($urandom));
            else begin
                sendBits(logic'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 7));
                idle($urandom_range(1, 2));
            end
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
